clk_divider_multi: RTL and testbench

- Multi-channel, run-time programmable clock divider for fabric-clocked peripherals (VGA, UART, PWM, LED scanning).
- NUM_CH independent channels; each has a programmable period and high time. Each produces a divided level output plus single-cycle rise/fall strobes for use as clock enables.
- Reconfiguration is glitch-free: new settings take effect only at a period boundary. A global sync input realigns the phases of all channels.

---
 rtl/clk_divider_multi.sv | 105 ++++++++++
 tb/tb_clk_divider_multi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel run-time programmable clock divider with glitch-free reconfiguration.
// Each channel drives a divided level, plus rise/fall strobes that can be used as clock enables.
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cfg_we,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                           cfg_div,
    input  logic [CNT_W-1:0]                           cfg_high,
    input  logic [NUM_CH-1:0]                          ch_en,
    input  logic                                       sync,
    output logic [NUM_CH-1:0]                          clk_out,
    output logic [NUM_CH-1:0]                          rise_tick,
    output logic [NUM_CH-1:0]                          fall_tick,
    output logic                                       cfg_err
);

    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);

    logic [NUM_CH-1:0][CNT_W-1:0] div_act;
    logic [NUM_CH-1:0][CNT_W-1:0] high_act;
    logic [NUM_CH-1:0][CNT_W-1:0] div_sh;
    logic [NUM_CH-1:0][CNT_W-1:0] high_sh;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;

    logic                         wr_valid;
    logic [NUM_CH-1:0]            wr_hit;
    logic [NUM_CH-1:0]            apply;
    logic [NUM_CH-1:0]            clk_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_div;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_high;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_nxt;

    // A write in flight counts as the pending value, so write+wrap or write+sync use it at once.
    always_comb begin
        wr_valid = cfg_we
                 && (cfg_div >= CNT_W'(2))
                 && (cfg_high >= CNT_W'(1))
                 && (cfg_high < cfg_div)
                 && (32'(cfg_ch) < 32'(NUM_CH));
        wr_hit    = '0;
        apply     = '0;
        clk_nxt   = '0;
        pend_div  = '0;
        pend_high = '0;
        cnt_nxt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]    = wr_valid && (cfg_ch == CH_W'(i));
            pend_div[i]  = wr_hit[i] ? cfg_div  : div_sh[i];
            pend_high[i] = wr_hit[i] ? cfg_high : high_sh[i];
            apply[i]     = sync || (cnt[i] == div_act[i] - CNT_W'(1));
            cnt_nxt[i]   = apply[i] ? '0 : cnt[i] + CNT_W'(1);
            clk_nxt[i]   = cnt_nxt[i] < (apply[i] ? pend_high[i] : high_act[i]);
        end
    end

    // A disabled channel parks its counter on the last count, so enabling it is simply a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_act[i]  <= DEF_DIV;
                high_act[i] <= DEF_HIGH;
                div_sh[i]   <= DEF_DIV;
                high_sh[i]  <= DEF_HIGH;
                cnt[i]      <= DEF_DIV - CNT_W'(1);
            end
            clk_out   <= '0;
            rise_tick <= '0;
            fall_tick <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !wr_valid;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    div_sh[i]  <= cfg_div;
                    high_sh[i] <= cfg_high;
                end
                if (ch_en[i]) begin
                    if (apply[i]) begin
                        div_act[i]  <= pend_div[i];
                        high_act[i] <= pend_high[i];
                    end
                    cnt[i]       <= cnt_nxt[i];
                    clk_out[i]   <= clk_nxt[i];
                    rise_tick[i] <= clk_nxt[i] && !clk_out[i];
                    fall_tick[i] <= !clk_nxt[i] && clk_out[i];
                end else begin
                    div_act[i]   <= pend_div[i];
                    high_act[i]  <= pend_high[i];
                    cnt[i]       <= pend_div[i] - CNT_W'(1);
                    clk_out[i]   <= 1'b0;
                    rise_tick[i] <= 1'b0;
                    fall_tick[i] <= clk_out[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi: a period/phase reference model predicts every cycle,
// and a separate monitor compares the DUT outputs after each rising edge.
module tb_clk_divider_multi;

    localparam int NUM_CH      = 6;
    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 2;
    localparam int CH_W        = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [CH_W-1:0]      cfg_ch = '0;
    logic [CNT_W-1:0]     cfg_div = '0;
    logic [CNT_W-1:0]     cfg_high = '0;
    logic [NUM_CH-1:0]    ch_en = '0;
    logic                 sync = 1'b0;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    rise_tick;
    logic [NUM_CH-1:0]    fall_tick;
    logic                 cfg_err;

    clk_divider_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_high(cfg_high), .ch_en(ch_en), .sync(sync), .clk_out(clk_out),
        .rise_tick(rise_tick), .fall_tick(fall_tick), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] lvl;
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] fall;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each channel is "in a period" at position pos, or idle while disabled.
    int   s_div[NUM_CH];
    int   s_high[NUM_CH];
    int   m_div[NUM_CH];
    int   m_high[NUM_CH];
    int   m_pos[NUM_CH];
    bit   m_run[NUM_CH];
    bit   m_out[NUM_CH];
    logic [NUM_CH-1:0] cur_en = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            s_div[c]  = DEFAULT_DIV;
            s_high[c] = DEFAULT_DIV / 2;
            m_div[c]  = DEFAULT_DIV;
            m_high[c] = DEFAULT_DIV / 2;
            m_pos[c]  = 0;
            m_run[c]  = 1'b0;
            m_out[c]  = 1'b0;
        end
    endtask

    // Drives one clock's worth of inputs and pushes the model's prediction for the next edge.
    task automatic applyStimulus(input bit we, input int ch, input int dv, input int hi,
                                 input logic [NUM_CH-1:0] en, input bit sy);
        exp_t e;
        bit   valid;
        int   pd;
        int   ph;
        bit   nout;
        @(negedge clk);
        cfg_we   = we;
        cfg_ch   = ch[CH_W-1:0];
        cfg_div  = dv[CNT_W-1:0];
        cfg_high = hi[CNT_W-1:0];
        ch_en    = en;
        sync     = sy;
        cur_en   = en;
        valid = we && (dv >= 2) && (hi >= 1) && (hi <= dv - 1) && (ch < NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            pd = (valid && ch == c) ? dv : s_div[c];
            ph = (valid && ch == c) ? hi : s_high[c];
            if (en[c]) begin
                if (!m_run[c] || sy || (m_pos[c] + 1 >= m_div[c])) begin
                    m_div[c]  = pd;
                    m_high[c] = ph;
                    m_pos[c]  = 0;
                end else begin
                    m_pos[c]++;
                end
                m_run[c] = 1'b1;
                nout = (m_pos[c] < m_high[c]);
            end else begin
                m_run[c] = 1'b0;
                nout = 1'b0;
            end
            e.lvl[c]  = nout;
            e.rise[c] = nout && !m_out[c];
            e.fall[c] = !nout && m_out[c];
            m_out[c]  = nout;
        end
        if (valid) begin
            s_div[ch]  = dv;
            s_high[ch] = hi;
        end
        e.err = we && !valid;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 0, cur_en, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        checkOutput({tag, "_rise"}, 32'(rise_tick), 32'd0);
        checkOutput({tag, "_fall"}, 32'(fall_tick), 32'd0);
        checkOutput({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("clk_out", 32'(clk_out), 32'(e.lvl));
                checkOutput("rise_tick", 32'(rise_tick), 32'(e.rise));
                checkOutput("fall_tick", 32'(fall_tick), 32'(e.fall));
                checkOutput("cfg_err", 32'(cfg_err), 32'(e.err));
            end
        end
    end

    initial begin
        modelReset();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Channel 0 at defaults toggles every cycle.
        applyStimulus(1'b0, 0, 0, 0, 6'b000001, 1'b0);
        idle(7);

        // Channel 1 at div 5 / high 2.
        applyStimulus(1'b1, 1, 5, 2, cur_en, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 6'b000011, 1'b0);
        idle(14);

        // Mid-period reprogram of channel 1 at position 1.
        for (int k = 0; k < 12 && m_pos[1] != 1; k++) idle(1);
        applyStimulus(1'b1, 1, 3, 1, cur_en, 1'b0);
        idle(12);

        // Rejected writes leave every waveform alone.
        applyStimulus(1'b1, 2, 1, 0, cur_en, 1'b0);
        applyStimulus(1'b1, 2, 5, 0, cur_en, 1'b0);
        applyStimulus(1'b1, 2, 4, 4, cur_en, 1'b0);
        applyStimulus(1'b1, 7, 4, 2, cur_en, 1'b0);
        applyStimulus(1'b1, 6, 4, 2, cur_en, 1'b0);
        idle(3);

        // Out-of-phase channels realigned by sync.
        applyStimulus(1'b1, 0, 4, 2, cur_en, 1'b0);
        applyStimulus(1'b1, 2, 6, 3, cur_en, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 6'b000101, 1'b0);
        idle(2);
        applyStimulus(1'b0, 0, 0, 0, 6'b000111, 1'b0);
        idle(4);
        applyStimulus(1'b0, 0, 0, 0, cur_en, 1'b1);
        idle(14);

        // Asynchronous reset in the middle of channel 1's high phase.
        applyStimulus(1'b1, 1, 5, 2, 6'b111111, 1'b0);
        for (int k = 0; k < 12 && !m_out[1]; k++) idle(1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkAllZero("async_reset");
        cfg_we = 1'b0;
        sync   = 1'b0;
        ch_en  = '0;
        cur_en = '0;
        repeat (3) @(negedge clk);
        checkAllZero("held_reset");
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b0, 0, 0, 0, 6'b111111, 1'b0);
        idle(8);

        // Random traffic: writes (valid and not), enable changes and sync pulses.
        for (int n = 0; n < 500; n++) begin
            logic [NUM_CH-1:0] en;
            en = cur_en;
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
            applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                          en, $urandom_range(0, 15) == 0);
        end

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
